// File: rtl/lsu_pkg.sv
// Shared types for the load/store controller: access size encodings, FSM states
// and the latched request record.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned OFF_W  = 2;

    // funct3 encodings; 3, 6 and 7 are illegal and fall outside the enum
    typedef enum logic [SIZE_W-1:0] {
        LDST_B  = 3'd0,
        LDST_H  = 3'd1,
        LDST_W  = 3'd2,
        LDST_BU = 3'd4,
        LDST_HU = 3'd5
    } ldst_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_WAIT,
        ST_RMW_WRITE
    } lsu_state_e;

    // Only the low halfword of store data is ever needed after IDLE
    typedef struct packed {
        logic [OFF_W-1:0]  off;
        logic [SIZE_W-1:0] size;
        logic [XLEN-1:0]   waddr;
        logic [15:0]       wd;
    } lsu_req_t;

    function automatic logic [XLEN-1:0] word_addr(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side and memory-side signals of the load/store controller.
interface lsu_if;
    import lsu_pkg::*;

    logic              core_req_i;
    logic              core_we_i;
    logic [SIZE_W-1:0] core_size_i;
    logic [XLEN-1:0]   core_addr_i;
    logic [XLEN-1:0]   core_wd_i;
    logic [XLEN-1:0]   core_rd_o;
    logic              core_stall_o;
    logic              misalign_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic [XLEN-1:0]   mem_wd_o;
    logic [XLEN-1:0]   mem_rd_i;

    // Environment side: core plus data memory
    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i,
        input  core_rd_o, core_stall_o, misalign_o, mem_req_o, mem_we_o, mem_addr_o, mem_wd_o
    );

    // Controller side
    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i, mem_rd_i,
        output core_rd_o, core_stall_o, misalign_o, mem_req_o, mem_we_o, mem_addr_o, mem_wd_o
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational datapath: alignment check on the live request, load lane
// extraction/extension and sub-word store merge on the latched request.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [SIZE_W-1:0] chk_size,
    input  logic [OFF_W-1:0]  chk_off,
    output logic              misalign,
    input  logic [SIZE_W-1:0] size,
    input  logic [OFF_W-1:0]  off,
    input  logic [XLEN-1:0]   rd_word,
    input  logic [15:0]       wd,
    output logic [XLEN-1:0]   load_data,
    output logic [XLEN-1:0]   merge_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        is_byte;
    logic        is_half;

    always_comb begin
        misalign = 1'b1;
        case (chk_size)
            LDST_B, LDST_BU: misalign = 1'b0;
            LDST_H, LDST_HU: misalign = chk_off[0];
            LDST_W:          misalign = (chk_off != 2'b00);
            default:         misalign = 1'b1;
        endcase
    end

    assign sel_byte = rd_word[{off, 3'b000} +: 8];
    assign sel_half = off[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = '0;
        case (size)
            LDST_B:  load_data = {{24{sel_byte[7]}}, sel_byte};
            LDST_BU: load_data = {24'h0, sel_byte};
            LDST_H:  load_data = {{16{sel_half[15]}}, sel_half};
            LDST_HU: load_data = {16'h0, sel_half};
            LDST_W:  load_data = rd_word;
            default: load_data = '0;
        endcase
    end

    assign is_byte = (size == LDST_B) || (size == LDST_BU);
    assign is_half = (size == LDST_H) || (size == LDST_HU);

    // Byte lanes at off (and off+1 for halfwords) take store data, others keep memory
    always_comb begin
        merge_data = rd_word;
        for (int i = 0; i < 4; i++) begin
            if ((is_byte || is_half) && (OFF_W'(i) == off)) begin
                merge_data[8*i +: 8] = wd[7:0];
            end else if (is_half && (OFF_W'(i) == OFF_W'(off + 2'd1))) begin
                merge_data[8*i +: 8] = wd[15:8];
            end
        end
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: maps byte/halfword/word core accesses onto a word-only
// synchronous memory, with read-modify-write for sub-word stores.
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    lsu_if.slave bus
);

    lsu_state_e      state;
    lsu_req_t        lat;
    logic            misalign;
    logic            store_word;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] merge_data;

    assign store_word = bus.core_we_i && (bus.core_size_i == LDST_W);

    lsu_align u_align (
        .chk_size   (bus.core_size_i),
        .chk_off    (bus.core_addr_i[1:0]),
        .misalign   (misalign),
        .size       (lat.size),
        .off        (lat.off),
        .rd_word    (bus.mem_rd_i),
        .wd         (lat.wd),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // State and latched request; SW and rejected accesses complete in IDLE
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            lat   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.core_req_i) begin
                        lat <= '{off:   bus.core_addr_i[1:0],
                                 size:  bus.core_size_i,
                                 waddr: word_addr(bus.core_addr_i),
                                 wd:    bus.core_wd_i[15:0]};
                        if (!misalign && !store_word) begin
                            state <= bus.core_we_i ? ST_RMW_WRITE : ST_LOAD_WAIT;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs are forced low during reset so an abandoned RMW never writes
    always_comb begin
        bus.core_rd_o    = '0;
        bus.core_stall_o = 1'b0;
        bus.misalign_o   = 1'b0;
        bus.mem_req_o    = 1'b0;
        bus.mem_we_o     = 1'b0;
        bus.mem_addr_o   = '0;
        bus.mem_wd_o     = '0;
        if (!rst_i) begin
            case (state)
                ST_IDLE: begin
                    if (bus.core_req_i) begin
                        if (misalign) begin
                            bus.misalign_o = 1'b1;
                        end else begin
                            bus.mem_req_o  = 1'b1;
                            bus.mem_addr_o = word_addr(bus.core_addr_i);
                            if (store_word) begin
                                bus.mem_we_o = 1'b1;
                                bus.mem_wd_o = bus.core_wd_i;
                            end else begin
                                bus.core_stall_o = 1'b1;
                            end
                        end
                    end
                end
                ST_LOAD_WAIT: begin
                    bus.core_rd_o = load_data;
                end
                ST_RMW_WRITE: begin
                    bus.mem_req_o  = 1'b1;
                    bus.mem_we_o   = 1'b1;
                    bus.mem_addr_o = lat.waddr;
                    bus.mem_wd_o   = merge_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset-during-RMW sequence and
// randomized accesses against a word-array reference model.
module tb_lsu_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic preload;

    always #5 clk = ~clk;

    lsu_if bus ();

    lsu_ctrl dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    // Synchronous word memory covering byte addresses 0x00..0x3F
    logic [31:0] mem [16];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) mem[i] = 32'h0;
            mem[4] = 32'h8899AABB;
        end else if (bus.mem_req_o) begin
            if (bus.mem_we_o) mem[bus.mem_addr_o[5:2]] = bus.mem_wd_o;
            else              bus.mem_rd_i <= mem[bus.mem_addr_o[5:2]];
        end
    end

    typedef struct {
        logic        mis;
        logic [31:0] rd;
        logic [31:0] rd0;
        int          stalls;
        logic        req_seen;
        logic        wr;
        logic [31:0] wa;
        logic [31:0] wdat;
        logic        timeout;
    } res_t;

    typedef struct {
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_mis;
        int          exp_stall;
        logic        exp_wr;
        logic [31:0] exp_wa;
        logic [31:0] exp_wd;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, got, exp);
        end
    endtask

    task automatic idle_cycle();
        bus.core_req_i = 1'b0;
        @(posedge clk); #1;
    endtask

    // Issue one access and follow it until the stall drops (bounded)
    task automatic run_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                          input logic [31:0] wd, output res_t r);
        int   cyc;
        logic st;
        r = '{default: '0};
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = we;
        bus.core_size_i = size;
        bus.core_addr_i = addr;
        bus.core_wd_i   = wd;
        cyc = 0;
        do begin
            @(negedge clk);
            if (cyc == 0) begin
                r.mis = bus.misalign_o;
                r.rd0 = bus.core_rd_o;
            end
            if (bus.mem_req_o) begin
                r.req_seen = 1'b1;
                if (bus.mem_we_o) begin
                    r.wr   = 1'b1;
                    r.wa   = bus.mem_addr_o;
                    r.wdat = bus.mem_wd_o;
                end
            end
            r.rd = bus.core_rd_o;
            st   = bus.core_stall_o;
            @(posedge clk); #1;
            cyc++;
        end while (st && cyc < 4);
        r.stalls  = cyc - 1;
        r.timeout = st;
    endtask

    vec_t        vecs [12];
    logic [31:0] ref_mem [16];

    initial begin
        res_t        r;
        logic        we;
        logic [2:0]  size;
        logic [31:0] addr, wd, w, v, mask, nw;
        logic [31:0] e_rd, e_wa, e_wd;
        logic        e_mis, e_wr, ok;
        int          e_stall, sh;
        logic [1:0]  off;
        logic [3:0]  wi;

        // we, size, addr, wd, exp_rd, exp_mis, exp_stall, exp_wr, exp_wa, exp_wd
        vecs[0]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'h8899AABB, 1'b0, 1, 1'b0, 32'h0,  32'h0};
        vecs[1]  = '{1'b0, 3'd0, 32'h13, 32'h0,        32'hFFFFFF88, 1'b0, 1, 1'b0, 32'h0,  32'h0};
        vecs[2]  = '{1'b0, 3'd4, 32'h13, 32'h0,        32'h00000088, 1'b0, 1, 1'b0, 32'h0,  32'h0};
        vecs[3]  = '{1'b0, 3'd1, 32'h12, 32'h0,        32'hFFFF8899, 1'b0, 1, 1'b0, 32'h0,  32'h0};
        vecs[4]  = '{1'b0, 3'd5, 32'h10, 32'h0,        32'h0000AABB, 1'b0, 1, 1'b0, 32'h0,  32'h0};
        vecs[5]  = '{1'b1, 3'd0, 32'h11, 32'h123456CC, 32'h0,        1'b0, 1, 1'b1, 32'h10, 32'h8899CCBB};
        vecs[6]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'h8899CCBB, 1'b0, 1, 1'b0, 32'h0,  32'h0};
        vecs[7]  = '{1'b1, 3'd1, 32'h11, 32'h0000FFFF, 32'h0,        1'b1, 0, 1'b0, 32'h0,  32'h0};
        vecs[8]  = '{1'b0, 3'd2, 32'h12, 32'h0,        32'h0,        1'b1, 0, 1'b0, 32'h0,  32'h0};
        vecs[9]  = '{1'b0, 3'd3, 32'h10, 32'h0,        32'h0,        1'b1, 0, 1'b0, 32'h0,  32'h0};
        vecs[10] = '{1'b1, 3'd2, 32'h14, 32'hDEADBEEF, 32'h0,        1'b0, 0, 1'b1, 32'h14, 32'hDEADBEEF};
        vecs[11] = '{1'b0, 3'd2, 32'h14, 32'h0,        32'hDEADBEEF, 1'b0, 1, 1'b0, 32'h0,  32'h0};

        // Reset with a live request: every output must stay low
        preload         = 1'b1;
        rst             = 1'b1;
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b0;
        bus.core_size_i = 3'd2;
        bus.core_addr_i = 32'h10;
        bus.core_wd_i   = 32'h0;
        @(negedge clk);
        check("rst mem_req", 32'(bus.mem_req_o), 32'h0);
        check("rst stall", 32'(bus.core_stall_o), 32'h0);
        check("rst rd", bus.core_rd_o, 32'h0);
        bus.core_size_i = 3'd3;
        #1;
        check("rst misalign", 32'(bus.misalign_o), 32'h0);
        @(posedge clk); #1;
        preload = 1'b0;
        rst     = 1'b0;
        idle_cycle();

        // Directed table, issued back to back
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd, r);
            check($sformatf("v%0d rd", i), r.rd, vecs[i].exp_rd);
            check($sformatf("v%0d rd_c0", i), r.rd0, 32'h0);
            check($sformatf("v%0d misalign", i), 32'(r.mis), 32'(vecs[i].exp_mis));
            check($sformatf("v%0d stalls", i), 32'(r.stalls), 32'(vecs[i].exp_stall));
            check($sformatf("v%0d mem_req", i), 32'(r.req_seen), 32'(!vecs[i].exp_mis));
            check($sformatf("v%0d write", i), 32'(r.wr), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d timeout", i), 32'(r.timeout), 32'h0);
            if (vecs[i].exp_wr) begin
                check($sformatf("v%0d wr_addr", i), r.wa, vecs[i].exp_wa);
                check($sformatf("v%0d wr_data", i), r.wdat, vecs[i].exp_wd);
            end
        end
        idle_cycle();

        // Reset pulsed during the write half of SB 0x10 must suppress the write
        run_op(1'b1, 3'd2, 32'h10, 32'h8899AABB, r);
        bus.core_req_i  = 1'b1;
        bus.core_we_i   = 1'b1;
        bus.core_size_i = 3'd0;
        bus.core_addr_i = 32'h10;
        bus.core_wd_i   = 32'h00000055;
        @(negedge clk);
        check("rmw_rst read stall", 32'(bus.core_stall_o), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rmw_rst mem_req", 32'(bus.mem_req_o), 32'h0);
        check("rmw_rst mem_we", 32'(bus.mem_we_o), 32'h0);
        check("rmw_rst stall", 32'(bus.core_stall_o), 32'h0);
        @(posedge clk); #1;
        rst            = 1'b0;
        bus.core_req_i = 1'b0;
        @(negedge clk);
        check("post_rst stall", 32'(bus.core_stall_o), 32'h0);
        check("post_rst mem_req", 32'(bus.mem_req_o), 32'h0);
        @(posedge clk); #1;
        run_op(1'b0, 3'd2, 32'h10, 32'h0, r);
        check("post_rst LW 0x10", r.rd, 32'h8899AABB);
        check("post_rst mem word", mem[4], 32'h8899AABB);
        idle_cycle();

        // Randomized accesses in 0x20..0x3F against the reference model
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
        for (int n = 0; n < 250; n++) begin
            we   = ($urandom_range(0, 4) < 2);
            size = we ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
            if (we && size == 3'd4) size = 3'd6;
            addr = 32'h20 + 32'($urandom_range(0, 31));
            wd   = $urandom;

            off  = addr[1:0];
            wi   = addr[5:2];
            w    = ref_mem[wi];
            sh   = 8 * int'(off);
            case (size)
                3'd0, 3'd4: ok = 1'b1;
                3'd1, 3'd5: ok = (off % 2 == 0);
                3'd2:       ok = (off == 2'd0);
                default:    ok = 1'b0;
            endcase
            e_rd = 32'h0; e_wr = 1'b0; e_wa = 32'h0; e_wd = 32'h0;
            e_mis = !ok;
            e_stall = 0;
            if (ok && !we) begin
                e_stall = 1;
                v = w >> sh;
                case (size)
                    3'd0:    e_rd = 32'($signed(v[7:0]));
                    3'd4:    e_rd = v & 32'hFF;
                    3'd1:    e_rd = 32'($signed(v[15:0]));
                    3'd5:    e_rd = v & 32'hFFFF;
                    default: e_rd = w;
                endcase
            end else if (ok) begin
                e_wr = 1'b1;
                if (size == 3'd2) begin
                    nw = wd;
                end else begin
                    e_stall = 1;
                    mask = ((size == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
                    nw   = (w & ~mask) | ((wd << sh) & mask);
                end
                ref_mem[wi] = nw;
                e_wa = addr & 32'hFFFF_FFFC;
                e_wd = nw;
            end

            run_op(we, size, addr, wd, r);
            check($sformatf("r%0d rd", n), r.rd, e_rd);
            check($sformatf("r%0d misalign", n), 32'(r.mis), 32'(e_mis));
            check($sformatf("r%0d stalls", n), 32'(r.stalls), 32'(e_stall));
            check($sformatf("r%0d write", n), 32'(r.wr), 32'(e_wr));
            if (e_wr) begin
                check($sformatf("r%0d wr_addr", n), r.wa, e_wa);
                check($sformatf("r%0d wr_data", n), r.wdat, e_wd);
            end
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        for (int i = 8; i < 16; i++) begin
            check($sformatf("final mem[%0d]", i), mem[i], ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
